// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester round-robin arbiter in front of a single-port data memory
//
// Ports:
//   clk, reset                      clock; synchronous active-high reset
//   req{0,1}_valid/ready            request handshake; ready asserted combinationally in IDLE
//   req{0,1}_addr/wdata/op/we       byte address, right-aligned store data, access op, store flag
//   resp{0,1}_valid/rdata/err       one-cycle completion pulse, load data, rejection flag
//   mem_addr/mem_wd/mem_op/mem_wr   data memory command, valid only during ACCESS
//   mem_rd                          combinational, already-extended read data from the memory
module dm_arbiter #(
  parameter int unsigned MEM_BYTES = 12288
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [2:0]  req0_op,
  input  logic        req0_we,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [2:0]  req1_op,
  input  logic        req1_we,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_op,
  output logic        mem_wr,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_next;

  logic        prio;      // requester that wins when both are valid
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_op;
  logic        r_we;
  logic        r_id;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        grant0, grant1, accept;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_op;
  logic        sel_we, sel_err;

  // Grant selection. Ready is held low while reset is asserted so that no
  // request is accepted (and lost) in a cycle that is about to be cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && (!req1_valid || !prio))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign accept    = grant0 | grant1;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign sel_op    = grant1 ? req1_op    : req0_op;
  assign sel_we    = grant1 ? req1_we    : req0_we;

  // Rejection is decided once at acceptance and carried with the request.
  // Stores with an unsigned op are meaningless, so they are rejected too.
  always_comb begin
    sel_err = 1'b0;
    if (sel_op > 3'd4)                                      sel_err = 1'b1;
    if (sel_op == 3'd0 && sel_addr[1:0] != 2'b00)           sel_err = 1'b1;
    if ((sel_op == 3'd1 || sel_op == 3'd2) && sel_addr[0])  sel_err = 1'b1;
    if (sel_addr >= MEM_BYTES)                              sel_err = 1'b1;
    if (sel_we && (sel_op == 3'd2 || sel_op == 3'd4))       sel_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= '0;
      r_we    <= 1'b0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        r_addr  <= sel_addr;
        r_wdata <= sel_wdata;
        r_op    <= sel_op;
        r_we    <= sel_we;
        r_id    <= grant1;
        r_err   <= sel_err;
        r_rdata <= '0;
        prio    <= ~grant1;
      end
      if (state == ACCESS && !r_err && !r_we)
        r_rdata <= mem_rd;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = grant0;
    req1_ready  = grant1;
    mem_addr    = '0;
    mem_wd      = '0;
    mem_op      = '0;
    mem_wr      = 1'b0;
    resp0_valid = 1'b0;
    resp0_rdata = '0;
    resp0_err   = 1'b0;
    resp1_valid = 1'b0;
    resp1_rdata = '0;
    resp1_err   = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr = r_addr;
        mem_wd   = r_wdata;
        mem_op   = r_op;
        mem_wr   = r_we & ~r_err;
      end
      RESP: begin
        if (r_id) begin
          resp1_valid = 1'b1;
          resp1_rdata = r_rdata;
          resp1_err   = r_err;
        end else begin
          resp0_valid = 1'b1;
          resp0_rdata = r_rdata;
          resp0_err   = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we, resp0_valid, resp0_err;
  logic [31:0] req0_addr, req0_wdata, resp0_rdata;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, req1_we, resp1_valid, resp1_err;
  logic [31:0] req1_addr, req1_wdata, resp1_rdata;
  logic [2:0]  req1_op;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_op;
  logic        mem_wr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_BYTES(12288)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_op(req0_op), .req0_we(req0_we),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_op(req1_op), .req1_we(req1_we),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_op(mem_op), .mem_wr(mem_wr),
    .mem_rd(mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit v, input logic [31:0] a,
                       input logic [2:0] op, input bit we, input logic [31:0] wd);
    if (id) begin
      req1_valid = v; req1_addr = a; req1_op = op; req1_we = we; req1_wdata = wd;
    end else begin
      req0_valid = v; req0_addr = a; req0_op = op; req0_we = we; req0_wdata = wd;
    end
  endtask

  // One complete single-requester transaction: accept, memory cycle, response.
  task automatic do_access(input string tag, input bit id, input logic [31:0] a,
                           input logic [2:0] op, input bit we, input logic [31:0] wd,
                           input logic [31:0] rd, input bit exp_err,
                           input logic [31:0] exp_rdata);
    step;
    drive(id, 1'b1, a, op, we, wd);
    #1;
    check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    step;
    // Scramble the requester inputs: the in-flight access must not follow them.
    drive(id, 1'b0, ~a, 3'd0, ~we, ~wd);
    mem_rd = rd;
    #1;
    check({tag, "_mem_wr"}, mem_wr, (we && !exp_err) ? 1 : 0);
    if (!exp_err) begin
      check({tag, "_mem_addr"}, mem_addr, a);
      check({tag, "_mem_op"}, mem_op, op);
      if (we) check({tag, "_mem_wd"}, mem_wd, wd);
    end
    step;
    mem_rd = 32'hA5A5_A5A5;
    #1;
    check({tag, "_resp_valid"}, id ? resp1_valid : resp0_valid, 1);
    check({tag, "_other_resp"}, id ? resp0_valid : resp1_valid, 0);
    check({tag, "_rdata"}, id ? resp1_rdata : resp0_rdata, exp_rdata);
    check({tag, "_err"}, id ? resp1_err : resp0_err, exp_err);
    check({tag, "_resp_mem_wr"}, mem_wr, 0);
  endtask

  initial begin
    reset = 1'b1;
    mem_rd = '0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step;
    step;
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_resp", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    reset = 1'b0;

    // Both requesters valid continuously: grants alternate starting at req0.
    step;
    drive(1'b0, 1'b1, 32'h0, 3'd0, 1'b0, '0);
    drive(1'b1, 1'b1, 32'h4, 3'd0, 1'b0, '0);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d_ready0", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_ready1", k), req1_ready, (k % 2 == 1) ? 1 : 0);
      step;
      check($sformatf("rr%0d_access_ready", k), {req0_ready, req1_ready}, 0);
      step;
      check($sformatf("rr%0d_resp0", k), resp0_valid, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_resp1", k), resp1_valid, (k % 2 == 1) ? 1 : 0);
      check($sformatf("rr%0d_resp_ready", k), {req0_ready, req1_ready}, 0);
      step;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);

    do_access("st_word",    1'b0, 32'h10,   3'd0, 1'b1, 32'hDEAD_BEEF, 32'h0,          1'b0, 32'h0);
    do_access("ld_byte",    1'b1, 32'h13,   3'd3, 1'b0, 32'h0,         32'hFFFF_FFDE,  1'b0, 32'hFFFF_FFDE);
    do_access("mis_half",   1'b0, 32'h21,   3'd1, 1'b0, 32'h0,         32'h1234_5678,  1'b1, 32'h0);
    do_access("oor_word",   1'b0, 32'h3000, 3'd0, 1'b0, 32'h0,         32'h1234_5678,  1'b1, 32'h0);
    do_access("st_uhalf",   1'b1, 32'h8,    3'd2, 1'b1, 32'h55AA,      32'h0,          1'b1, 32'h0);
    do_access("bad_op",     1'b1, 32'h0,    3'd5, 1'b0, 32'h0,         32'h1111_1111,  1'b1, 32'h0);
    do_access("ld_top",     1'b0, 32'h2FFE, 3'd2, 1'b0, 32'h0,         32'h0000_BEEF,  1'b0, 32'h0000_BEEF);
    do_access("mis_word",   1'b1, 32'h6,    3'd0, 1'b1, 32'hCAFE,      32'h0,          1'b1, 32'h0);
    do_access("st_byte",    1'b1, 32'h2FFF, 3'd3, 1'b1, 32'h0000_0077, 32'h0,          1'b0, 32'h0);

    // Reset during the ACCESS cycle of a store aborts it without a response.
    step;
    drive(1'b0, 1'b1, 32'h40, 3'd0, 1'b1, 32'h0BAD_F00D);
    #1;
    check("abort_ready0", req0_ready, 1);
    step;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    #1;
    check("abort_access_wr", mem_wr, 1);
    step;
    reset = 1'b0;
    #1;
    check("abort_wr_low", mem_wr, 0);
    check("abort_no_resp", {resp0_valid, resp1_valid}, 0);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 1'b0, '0);
    drive(1'b1, 1'b1, 32'h4, 3'd0, 1'b0, '0);
    #1;
    check("abort_next_ready0", req0_ready, 1);
    check("abort_next_ready1", req1_ready, 0);
    step;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("post_abort_wr", mem_wr, 0);
    step;
    check("post_abort_resp0", resp0_valid, 1);
    check("post_abort_resp1", resp1_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 12288, byte size of the data memory; addresses at or above it are out of range.
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a pending access.
REQ-005 reqN_ready  output  1  access accepted this cycle when high with reqN_valid.
REQ-006 reqN_addr  input  32  byte address.
REQ-007 reqN_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
REQ-008 reqN_op  input  3  0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5-7 invalid.
REQ-009 reqN_we  input  1  1 store, 0 load.
REQ-010 respN_valid  output  1  one-cycle completion pulse for requester N.
REQ-011 respN_rdata  output  32  load result, extended per op; 0 for stores and errors.
REQ-012 respN_err  output  1  access rejected: misaligned, invalid op, out of range, or store with op 2/4.
REQ-013 mem_addr  output  32  address to the data memory.
REQ-014 mem_wd  output  32  store data to the data memory.
REQ-015 mem_op  output  3  op code to the data memory, same encoding as reqN_op.
REQ-016 mem_wr  output  1  write strobe to the data memory.
REQ-017 mem_rd  input  32  combinational read data from the data memory, already extended per mem_op.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; exactly one request in flight at any time.
REQ-019 IDLE: the arbiter selects one requester with valid high and drives only that requester's reqN_ready high, combinationally, in the same cycle.
REQ-020 Both valid high: grant goes to the requester named by the priority pointer; otherwise to the single valid requester.
REQ-021 Priority pointer resets to 0 and, on each accepted request, points to the other requester (round-robin).
REQ-022 On acceptance the arbiter registers addr, wdata, op, we, and requester id, then moves to ACCESS.
REQ-023 Error check at acceptance: op>4; op 0 with addr[1:0]!=0; op 1/2 with addr[0]!=0; addr>=MEM_BYTES; we=1 with op 2 or 4.
REQ-024 ACCESS, legal request: drive mem_addr/mem_wd/mem_op from the registers; mem_wr=we for exactly this one cycle; capture mem_rd at clock end for loads.
REQ-025 ACCESS, erroneous request: mem_wr stays 0 and no capture; error flag carried to RESP.
REQ-026 RESP: respN_valid=1 for the owning requester only, for one cycle; rdata = captured data (load) or 0; err per REQ-023; then IDLE.
REQ-027 Latency: accept at cycle t, memory cycle t+1, response at t+2; maximum throughput one access per 3 cycles.
REQ-028 reqN_ready is 0 in ACCESS and RESP; requests held valid there wait and are not lost.
REQ-029 mem_wr is 0 in all states other than ACCESS; mem_addr/mem_wd/mem_op are 0 in IDLE.
REQ-030 Requester inputs may change after acceptance without effect on the in-flight access.

Reset
REQ-031 reset at any posedge forces IDLE, pointer 0, all outputs 0, and registered request cleared.
REQ-032 reset during ACCESS suppresses mem_wr from the next cycle; no response is issued for the aborted access.
REQ-033 Memory contents are outside the scope of this block's reset.

Verification
REQ-034 req0 store op0 addr 0x10 data 0xDEADBEEF -> ready0 at t, mem_wr=1 at t+1 with mem_addr 0x10, resp0_valid at t+2 with err 0 and rdata 0.
REQ-035 Then req1 load op3 addr 0x13 -> mem_op 3 at t+1; with mem_rd=0xFFFFFFDE, resp1_rdata 0xFFFFFFDE at t+2.
REQ-036 req0 and req1 valid continuously from reset -> grants alternate 0,1,0,1 with one response every 3 cycles.
REQ-037 req0 load op1 addr 0x21, then op0 addr 0x3000 -> each gives resp0_err=1 and rdata 0; mem_wr stays 0 throughout.
REQ-038 reset asserted in the ACCESS cycle of a store -> mem_wr low from the next cycle; no resp pulse; the next request is granted to req0.
